// File: rtl/seq_run_ctrl.sv
// seq_run_ctrl: run controller for an LFSR / sequence-detector measurement.
//
// A start pulse in IDLE launches a run: one CLEAR cycle pulses seq_clr_o to
// reset the LFSR, detector and display counter, then RUN enables them with
// seq_en_o and counts detector ticks. The run ends on max_tick_i, the LFSR
// end-of-period strobe. On entry to DONE the saturating match count, its
// overflow flag and the timeout flag are latched and held. abort_i cancels a
// run without touching the latched values, or, in DONE, clears them.
//
// Optional feature, macro SEQ_RUN_TIMEOUT_EN: a RUN-state cycle counter
// forces DONE with timeout_o=1 after TIMEOUT_CYCLES cycles without max_tick_i.
// When the macro is undefined the counter is absent and timeout_o is 0.
//
// Parameters:
//   CNT_W          width of the match counter and of result_o
//   TIMEOUT_CYCLES RUN-state cycle limit (timeout build only)
//
// Ports:
//   clk_i       clock (the divided system clock), rising edge
//   rst_ni      asynchronous active-low reset
//   start_i     single-cycle request for a new run
//   abort_i     level; cancels a run, or clears the result in DONE
//   max_tick_i  end-of-period strobe from the LFSR
//   tick_i      match strobe from the sequence detector
//   seq_clr_o   one-cycle clear to LFSR, detector and display counter
//   seq_en_o    enable to LFSR and detector
//   busy_o      high in CLEAR and RUN
//   done_o      high in DONE
//   result_o    match count latched at the end of a run
//   ovf_o       latched run saturated the match counter
//   timeout_o   latched run ended on the cycle limit

module seq_run_ctrl #(
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             max_tick_i,
  input  logic             tick_i,
  output logic             seq_clr_o,
  output logic             seq_en_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] result_o,
  output logic             ovf_o,
  output logic             timeout_o
);

  typedef enum logic [1:0] {StIdle, StClear, StRun, StDone} state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             sat_q, sat_d, sat_inc;
  logic [CNT_W-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             seq_clr_q, seq_en_q, busy_q, done_q;
  logic             seq_clr_d, seq_en_d, busy_d, done_d;
  logic             res_load;  // entering DONE: latch count and flags
  logic             res_clr;   // abort in DONE: clear latched values
  logic             hit_limit; // RUN cycle limit reached this cycle

  // Count including this cycle's tick, so a tick coinciding with the end of
  // the run lands in the latched result. Saturates instead of wrapping.
  always_comb begin
    cnt_inc = cnt_q;
    sat_inc = sat_q;
    if (tick_i) begin
      if (cnt_q == CntMax) begin
        sat_inc = 1'b1;
      end else begin
        cnt_inc = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    res_load = 1'b0;
    res_clr  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i && !abort_i) begin
          state_d = StClear;
        end
      end
      StClear: begin
        cnt_d   = '0;
        sat_d   = 1'b0;
        state_d = StRun;
      end
      StRun: begin
        cnt_d = cnt_inc;
        sat_d = sat_inc;
        // abort outranks both ways of finishing the run
        if (abort_i) begin
          state_d = StIdle;
        end else if (max_tick_i || hit_limit) begin
          state_d  = StDone;
          res_load = 1'b1;
        end
      end
      StDone: begin
        if (abort_i) begin
          state_d = StIdle;
          res_clr = 1'b1;
        end else if (start_i) begin
          state_d = StClear;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    result_d = result_q;
    ovf_d    = ovf_q;
    if (res_clr) begin
      result_d = '0;
      ovf_d    = 1'b0;
    end else if (res_load) begin
      result_d = cnt_inc;
      ovf_d    = sat_inc;
    end
  end

  // Outputs are registered copies of the next-state decode, so they change
  // together with the state and have no input-to-output path.
  always_comb begin
    seq_clr_d = (state_d == StClear);
    seq_en_d  = (state_d == StRun);
    busy_d    = (state_d == StClear) || (state_d == StRun);
    done_d    = (state_d == StDone);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      seq_clr_q <= 1'b0;
      seq_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
      seq_clr_q <= seq_clr_d;
      seq_en_q  <= seq_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

`ifdef SEQ_RUN_TIMEOUT_EN
  localparam int unsigned CycW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CycW-1:0] CycLast = CycW'(TIMEOUT_CYCLES - 1);

  logic [CycW-1:0] cyc_q, cyc_d;
  logic            timeout_q, timeout_d;

  assign hit_limit = (state_q == StRun) && (cyc_q == CycLast);

  always_comb begin
    cyc_d = cyc_q;
    if (state_q == StClear) begin
      cyc_d = '0;
    end else if (state_q == StRun && !hit_limit) begin
      cyc_d = cyc_q + CycW'(1);
    end
  end

  // A run that ends with max_tick_i is never a timeout, even on the limit cycle.
  always_comb begin
    timeout_d = timeout_q;
    if (res_clr) begin
      timeout_d = 1'b0;
    end else if (res_load) begin
      timeout_d = !max_tick_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cyc_q     <= cyc_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign hit_limit = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign seq_clr_o = seq_clr_q;
  assign seq_en_o  = seq_en_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign result_o  = result_q;
  assign ovf_o     = ovf_q;

endmodule

// File: doc/seq_run_ctrl.md
SEQ_RUN_CTRL -- requirements
Module: seq_run_ctrl

Interface
REQ-001 The block SHALL take parameter CNT_W, default 16, as the width of the match counter and the result register.
REQ-002 The block SHALL take parameter TIMEOUT_CYCLES, default 65535, as the RUN-state cycle limit; it is used only when the timeout feature is compiled in.
REQ-003 Port clk, input, 1 bit: the single clock (the divided system clock); all logic is on its rising edge.
REQ-004 Port reset, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 Port start, input, 1 bit: single-cycle pulse requesting a new detection run.
REQ-006 Port abort, input, 1 bit: level; cancels the current run or clears the result.
REQ-007 Port max_tick, input, 1 bit: end-of-period strobe from the LFSR.
REQ-008 Port tick, input, 1 bit: match strobe from the sequence detector.
REQ-009 Port seq_clr, output, 1 bit: one-cycle clear to the LFSR, detector and display counter.
REQ-010 Port seq_en, output, 1 bit: enable to the LFSR and detector.
REQ-011 Port busy, output, 1 bit: high in CLEAR and RUN.
REQ-012 Port done, output, 1 bit: high in DONE.
REQ-013 Port result, output, CNT_W bits: match count latched at the end of a run.
REQ-014 Port ovf, output, 1 bit: the latched run saturated the counter.
REQ-015 Port timeout, output, 1 bit: the latched run ended on the cycle limit rather than on max_tick.

Function
REQ-016 The FSM SHALL have four states: IDLE, CLEAR, RUN, DONE.
REQ-017 IDLE: on start && !abort, go to CLEAR; otherwise hold.
REQ-018 CLEAR SHALL last exactly one cycle with seq_clr=1 and seq_en=0, clear the match counter, then go to RUN unconditionally.
REQ-019 RUN SHALL hold seq_en=1; each cycle with tick=1 increments the match counter.
REQ-020 The match counter SHALL saturate at 2^CNT_W-1; a tick at saturation sets an internal overflow flag and does not wrap.
REQ-021 RUN with max_tick=1: go to DONE; a tick in that same cycle SHALL be counted and included in result.
REQ-022 On entry to DONE, result, ovf and timeout SHALL load in the same edge; they remain stable throughout DONE.
REQ-023 abort in RUN SHALL take priority over max_tick and the timeout; go to IDLE, and result, ovf and timeout are not updated.
REQ-024 DONE: abort goes to IDLE and clears result, ovf and timeout to 0; otherwise start goes to CLEAR, and result stays held until the next DONE entry.
REQ-025 start SHALL be ignored in CLEAR and RUN.
REQ-026 Outputs SHALL be registered or decoded from the state only, with no combinational path from any input to any output.
REQ-027 Latency: seq_clr is high the cycle after start is sampled; seq_en rises the cycle after that; done rises the cycle after max_tick is sampled.

Reset
REQ-028 Reset asserted SHALL force, asynchronously: state=IDLE, seq_clr=0, seq_en=0, busy=0, done=0, result=0, ovf=0, timeout=0, match counter=0, cycle counter=0.
REQ-029 Reset asserted mid-run SHALL abandon the run with no DONE entry; after deassertion the block waits in IDLE for start.

Configuration
REQ-030 With macro SEQ_RUN_TIMEOUT_EN defined, a cycle counter SHALL clear in CLEAR and count in RUN. If it reaches TIMEOUT_CYCLES-1 without max_tick, the FSM goes to DONE with timeout=1. max_tick in that same cycle SHALL win and give timeout=0.
REQ-031 Without SEQ_RUN_TIMEOUT_EN, the cycle counter SHALL be absent, timeout SHALL be tied to 0, and RUN SHALL wait indefinitely for max_tick or abort.

Verification
REQ-032 Basic run: reset, start pulse, 3 ticks in RUN, max_tick 20 cycles later -> seq_clr one cycle, done=1, result=3, ovf=0.
REQ-033 Final-cycle tick: tick and max_tick in the same cycle after 5 earlier ticks -> result=6.
REQ-034 Saturation: CNT_W=4, 17 ticks then max_tick -> result=15, ovf=1.
REQ-035 Abort priority: abort and max_tick in the same RUN cycle -> state IDLE, done=0, result unchanged from the previous run.
REQ-036 Timeout: SEQ_RUN_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, no max_tick -> done=1 and timeout=1 after 8 RUN cycles; repeat without the macro -> still busy after 100 cycles.
REQ-037 Reset mid-run: reset low during RUN -> all outputs 0 immediately, asynchronously; start after release -> a fresh run with result counting from 0.
